// File: rtl/punc_console_io.sv
// Memory-mapped console I/O for PUnC LC3: KBSR/KBDR/DSR/DDR decode, keyboard FIFO, display handshake.
// Optional keyboard interrupt enable (KBSR[14]) and kb_irq output under `PUNC_IO_IRQ_EN.
module punc_console_io #(
  parameter logic [15:0] BASE_ADDR     = 16'hFE00,
  parameter int unsigned KB_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_r_addr,
  input  logic        cpu_r_en,
  output logic [15:0] cpu_r_data,
  input  logic [15:0] cpu_w_addr,
  input  logic [15:0] cpu_w_data,
  input  logic        cpu_w_en,
  output logic [15:0] mem_r_addr,
  input  logic [15:0] mem_r_data,
  output logic [15:0] mem_w_addr,
  output logic [15:0] mem_w_data,
  output logic        mem_w_en,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready
`ifdef PUNC_IO_IRQ_EN
  ,
  output logic        kb_irq
`endif
);

  localparam logic [15:0] KBSR_ADDR = BASE_ADDR;
  localparam logic [15:0] KBDR_ADDR = BASE_ADDR + 16'd2;
  localparam logic [15:0] DSR_ADDR  = BASE_ADDR + 16'd4;
  localparam logic [15:0] DDR_ADDR  = BASE_ADDR + 16'd6;
  localparam int unsigned PW = $clog2(KB_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    fifo_mem [KB_FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overrun;
  logic          full;
  logic          nonempty;
  logic          push;
  logic          pop;
  logic          dev_w_hit;
  logic          ddr_wr;
  logic          ddr_accept;
  logic          dsr_wr;
  logic          kbsr_wr;
  logic          ie;

  assign full     = (count == CW'(KB_FIFO_DEPTH));
  assign nonempty = (count != '0);
  assign kb_ready = !full;
  assign push     = kb_valid && kb_ready;
  assign pop      = cpu_r_en && (cpu_r_addr == KBDR_ADDR) && nonempty;

  assign mem_r_addr = cpu_r_addr;
  assign mem_w_addr = cpu_w_addr;
  assign mem_w_data = cpu_w_data;

  assign dev_w_hit  = (cpu_w_addr == KBSR_ADDR) || (cpu_w_addr == KBDR_ADDR) ||
                      (cpu_w_addr == DSR_ADDR)  || (cpu_w_addr == DDR_ADDR);
  assign mem_w_en   = cpu_w_en && !dev_w_hit;
  assign ddr_wr     = cpu_w_en && (cpu_w_addr == DDR_ADDR);
  assign ddr_accept = ddr_wr && (!disp_valid || disp_ready);
  assign dsr_wr     = cpu_w_en && (cpu_w_addr == DSR_ADDR);
  assign kbsr_wr    = cpu_w_en && (cpu_w_addr == KBSR_ADDR);

`ifdef PUNC_IO_IRQ_EN
  assign kb_irq = ie && nonempty;
`endif

  always_comb begin
    cpu_r_data = mem_r_data;
    case (cpu_r_addr)
`ifdef PUNC_IO_IRQ_EN
      KBSR_ADDR: cpu_r_data = {nonempty, ie, full, 13'b0};
`else
      KBSR_ADDR: cpu_r_data = {nonempty, full, 14'b0};
`endif
      KBDR_ADDR: cpu_r_data = nonempty ? {8'h00, fifo_mem[rd_ptr]} : '0;
      DSR_ADDR:  cpu_r_data = {!disp_valid, overrun, 14'b0};
      DDR_ADDR:  cpu_r_data = {8'h00, disp_data};
      default:   cpu_r_data = mem_r_data;
    endcase
  end

  // Storage is not reset; resetting the pointers and count discards its contents.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= kb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      overrun    <= 1'b0;
      ie         <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A rejected DDR write implies disp_valid && !disp_ready, so no handshake can coincide.
      if (ddr_accept) begin
        disp_data  <= cpu_w_data[7:0];
        disp_valid <= 1'b1;
      end else if (ddr_wr) begin
        overrun <= 1'b1;
      end else if (disp_valid && disp_ready) begin
        disp_valid <= 1'b0;
      end
      if (dsr_wr)
        overrun <= 1'b0;

`ifdef PUNC_IO_IRQ_EN
      if (kbsr_wr)
        ie <= cpu_w_data[14];
`else
      ie <= 1'b0;
`endif
    end
  end

`ifndef PUNC_IO_IRQ_EN
  logic unused_kbsr_wr;
  assign unused_kbsr_wr = kbsr_wr;
`endif

endmodule

// File: tb/tb_punc_console_io.sv
// Self-checking bench for punc_console_io: scoreboard queues for keyboard and display bytes.
// Honours `PUNC_IO_IRQ_EN for the KBSR layout and kb_irq checks.
module tb_punc_console_io;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_r_addr = '0;
  logic        cpu_r_en = 1'b0;
  logic [15:0] cpu_r_data;
  logic [15:0] cpu_w_addr = '0;
  logic [15:0] cpu_w_data = '0;
  logic        cpu_w_en = 1'b0;
  logic [15:0] mem_r_addr;
  logic [15:0] mem_r_data = 16'h1234;
  logic [15:0] mem_w_addr;
  logic [15:0] mem_w_data;
  logic        mem_w_en;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = '0;
  logic        kb_ready;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready = 1'b0;
`ifdef PUNC_IO_IRQ_EN
  logic        kb_irq;
`endif

  punc_console_io #(.BASE_ADDR(16'hFE00), .KB_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cpu_r_addr(cpu_r_addr), .cpu_r_en(cpu_r_en), .cpu_r_data(cpu_r_data),
    .cpu_w_addr(cpu_w_addr), .cpu_w_data(cpu_w_data), .cpu_w_en(cpu_w_en),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready)
`ifdef PUNC_IO_IRQ_EN
    , .kb_irq(kb_irq)
`endif
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0] q_kb[$];
  logic [7:0] q_disp[$];
  logic       m_dv = 1'b0;
  logic       m_ov = 1'b0;
  logic       m_ie = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_kbsr();
    logic nz;
    logic fl;
    nz = (q_kb.size() != 0);
    fl = (q_kb.size() == DEPTH);
`ifdef PUNC_IO_IRQ_EN
    return {nz, m_ie, fl, 13'b0};
`else
    return {nz, fl, 14'b0};
`endif
  endfunction

  function automatic logic [15:0] exp_dsr();
    return {!m_dv, m_ov, 14'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    kb_valid = 1'b0;
    cpu_w_en = 1'b0;
    cpu_r_en = 1'b0;
    q_kb.delete();
    q_disp.delete();
    m_dv = 1'b0;
    m_ov = 1'b0;
    m_ie = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    cpu_r_addr = addr;
    cpu_r_en   = 1'b0;
    #1;
    check(tag, cpu_r_data, exp);
  endtask

  task automatic kb_push(input logic [7:0] b);
    kb_valid = 1'b1;
    kb_data  = b;
    #1;
    check("kb_ready", {15'b0, kb_ready}, {15'b0, q_kb.size() < DEPTH});
    if (q_kb.size() < DEPTH) q_kb.push_back(b);
    tick();
    kb_valid = 1'b0;
  endtask

  task automatic kb_pop(input string tag);
    logic [15:0] exp;
    cpu_r_addr = KBDR;
    cpu_r_en   = 1'b1;
    #1;
    exp = (q_kb.size() != 0) ? {8'h00, q_kb[0]} : 16'h0000;
    check(tag, cpu_r_data, exp);
    if (q_kb.size() != 0) void'(q_kb.pop_front());
    tick();
    cpu_r_en = 1'b0;
  endtask

  task automatic kb_both(input string tag, input logic [7:0] b);
    logic [15:0] exp;
    logic        was_full;
    kb_valid   = 1'b1;
    kb_data    = b;
    cpu_r_addr = KBDR;
    cpu_r_en   = 1'b1;
    #1;
    was_full = (q_kb.size() == DEPTH);
    exp = (q_kb.size() != 0) ? {8'h00, q_kb[0]} : 16'h0000;
    check(tag, cpu_r_data, exp);
    check({tag, "_rdy"}, {15'b0, kb_ready}, {15'b0, !was_full});
    if (q_kb.size() != 0) void'(q_kb.pop_front());
    if (!was_full) q_kb.push_back(b);
    tick();
    kb_valid = 1'b0;
    cpu_r_en = 1'b0;
  endtask

  task automatic cpu_write(input string tag, input logic [15:0] addr, input logic [15:0] data);
    logic dev;
    cpu_w_addr = addr;
    cpu_w_data = data;
    cpu_w_en   = 1'b1;
    #1;
    dev = (addr == KBSR) || (addr == KBDR) || (addr == DSR) || (addr == DDR);
    check({tag, "_wen"}, {15'b0, mem_w_en}, {15'b0, !dev});
    check({tag, "_wad"}, mem_w_addr, addr);
    check({tag, "_wdt"}, mem_w_data, data);
    if (addr == DDR) begin
      if (!m_dv || disp_ready) begin
        if (m_dv) check({tag, "_hs"}, {8'h00, disp_data}, {8'h00, q_disp.pop_front()});
        q_disp.push_back(data[7:0]);
        m_dv = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end
    if (addr == DSR) m_ov = 1'b0;
`ifdef PUNC_IO_IRQ_EN
    if (addr == KBSR) m_ie = data[14];
`endif
    tick();
    cpu_w_en = 1'b0;
  endtask

  task automatic disp_take(input string tag);
    disp_ready = 1'b1;
    #1;
    check({tag, "_dv"}, {15'b0, disp_valid}, {15'b0, m_dv});
    if (q_disp.size() != 0) check({tag, "_dd"}, {8'h00, disp_data}, {8'h00, q_disp.pop_front()});
    m_dv = 1'b0;
    tick();
    disp_ready = 1'b0;
  endtask

  initial begin
    tick();
    do_reset();

    rd_check("rst_kbsr", KBSR, exp_kbsr());
    rd_check("rst_dsr", DSR, exp_dsr());
    rd_check("rst_ddr", DDR, 16'h0000);
    check("rst_kbrdy", {15'b0, kb_ready}, 16'h0001);
    check("rst_dv", {15'b0, disp_valid}, 16'h0000);
    kb_pop("rst_kbdr_empty");

    kb_push(8'h41);
    kb_push(8'h42);
    rd_check("two_kbsr", KBSR, exp_kbsr());
    kb_pop("pop41");
    kb_pop("pop42");
    rd_check("empty_kbsr", KBSR, exp_kbsr());

    for (int unsigned i = 1; i <= 4; i++) kb_push(8'(i));
    rd_check("full_kbsr", KBSR, exp_kbsr());
    kb_push(8'h05);
    kb_both("full_both", 8'h05);
    kb_push(8'h05);
    for (int unsigned i = 0; i < 4; i++) kb_pop("drain");
    rd_check("drain_kbsr", KBSR, exp_kbsr());

    kb_push(8'h10);
    kb_both("mid_both", 8'h11);
    rd_check("mid_kbsr", KBSR, exp_kbsr());
    kb_pop("pop11");
    kb_both("empty_both", 8'h22);
    kb_pop("pop22");

    kb_push(8'h33);
    cpu_r_addr = KBDR;
    cpu_r_en   = 1'b0;
    tick();
    rd_check("noen_kbsr", KBSR, exp_kbsr());
    kb_pop("pop33");

    cpu_write("ddr1", DDR, 16'h1263);
    check("ddr1_dv", {15'b0, disp_valid}, {15'b0, m_dv});
    rd_check("ddr1_ddr", DDR, 16'h0063);
    rd_check("ddr1_dsr", DSR, exp_dsr());
    cpu_write("ddr2", DDR, 16'h0055);
    rd_check("ovr_dsr", DSR, exp_dsr());
    rd_check("ovr_ddr", DDR, 16'h0063);
    disp_take("take63");
    rd_check("taken_dsr", DSR, exp_dsr());
    cpu_write("dsrw", DSR, 16'hFFFF);
    rd_check("clr_dsr", DSR, exp_dsr());

    cpu_write("ddr12", DDR, 16'h0012);
    disp_ready = 1'b1;
    cpu_write("ddr34", DDR, 16'h0034);
    disp_ready = 1'b0;
    rd_check("b2b_dsr", DSR, exp_dsr());
    disp_take("take34");

    cpu_write("mem3000", 16'h3000, 16'hBEEF);
    cpu_write("devddr", DDR, 16'hBEEF);
    disp_take("takeEF");
    cpu_write("mem_fe01", 16'hFE01, 16'hBEEF);
    cpu_write("kbdr_w", KBDR, 16'h00AA);
    rd_check("kbdrw_kbsr", KBSR, exp_kbsr());
    mem_r_data = 16'h5A5A;
    rd_check("rd3000", 16'h3000, 16'h5A5A);
    check("raddr", mem_r_addr, 16'h3000);
    rd_check("rdfe01", 16'hFE01, 16'h5A5A);
    rd_check("rdfe07", 16'hFE07, 16'h5A5A);

    cpu_write("kbsr_w", KBSR, 16'h4000);
    rd_check("kbsrw_kbsr", KBSR, exp_kbsr());
    kb_push(8'h0A);
    rd_check("irq_kbsr", KBSR, exp_kbsr());
`ifdef PUNC_IO_IRQ_EN
    check("irq_on", {15'b0, kb_irq}, 16'h0001);
`endif
    kb_pop("pop0A");
`ifdef PUNC_IO_IRQ_EN
    check("irq_off", {15'b0, kb_irq}, 16'h0000);
`endif

    kb_push(8'h77);
    kb_push(8'h78);
    cpu_write("pre_rst_ddr", DDR, 16'h0099);
    kb_valid   = 1'b1;
    kb_data    = 8'hEE;
    cpu_w_addr = DDR;
    cpu_w_data = 16'h0011;
    cpu_w_en   = 1'b1;
    do_reset();
    rd_check("mid_rst_kbsr", KBSR, exp_kbsr());
    rd_check("mid_rst_dsr", DSR, exp_dsr());
    check("mid_rst_dv", {15'b0, disp_valid}, 16'h0000);
    kb_pop("mid_rst_kbdr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/punc_console_io.md
Name: punc_console_io

Overview:
- Memory-mapped console I/O unit for the PUnC LC3 processor.
- Sits between the datapath's memory port and the Memory block.
- Decodes the LC3 device registers KBSR/KBDR/DSR/DDR at BASE_ADDR+0/+2/+4/+6. Passes all other addresses through to Memory unchanged.
- Buffers keyboard bytes in a small FIFO and drives a valid/ready display interface.

Parameters:
- BASE_ADDR, 16'hFE00, address of KBSR; KBDR=+2, DSR=+4, DDR=+6.
- KB_FIFO_DEPTH, 4, keyboard FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cpu_r_addr  in  16  datapath read address
- cpu_r_en  in  1  read strobe; qualifies KBDR pop
- cpu_r_data  out  16  read data to datapath (combinational)
- cpu_w_addr  in  16  datapath write address
- cpu_w_data  in  16  datapath write data
- cpu_w_en  in  1  datapath write enable
- mem_r_addr  out  16  to Memory r_addr_0; equals cpu_r_addr
- mem_r_data  in  16  from Memory r_data_0
- mem_w_addr  out  16  to Memory; equals cpu_w_addr
- mem_w_data  out  16  to Memory; equals cpu_w_data
- mem_w_en  out  1  cpu_w_en gated off for device addresses
- kb_valid  in  1  keyboard byte offered
- kb_data  in  8  keyboard byte
- kb_ready  out  1  FIFO not full (combinational)
- disp_valid  out  1  display byte pending
- disp_data  out  8  display byte
- disp_ready  in  1  display accepts byte

Behaviour:
- Reset values:
  - FIFO empty; read and write pointers 0.
  - disp_valid=0, disp_data=0, overrun=0.
  - kb_ready=1 after reset.
- Read mux (combinational, zero latency):
  - KBSR -> {nonempty, full, 14'b0}.
  - KBDR -> {8'b0, FIFO head}; 16'h0000 when empty.
  - DSR -> {!disp_valid, overrun, 14'b0}.
  - DDR -> {8'b0, disp_data}.
  - Any other address -> mem_r_data.
  - Only exact even device addresses decode. BASE+1/+3/+5/+7 pass through to Memory.
- Pop: cpu_r_en && cpu_r_addr==KBDR && nonempty pops at the clock edge. Data is returned in the same cycle as the pop. cpu_r_en=0 never pops.
- Push: kb_valid && kb_ready writes kb_data at the clock edge. KBSR reflects the push on the next cycle.
- Simultaneous push and pop:
  - Not full: both occur; count is unchanged.
  - Full: kb_ready=0, so only the pop occurs.
  - Empty: push only; the pop returns 0 and does not pop.
- Pointer wrap-around is modulo KB_FIFO_DEPTH. Count width is clog2(DEPTH)+1.
- Writes to any device address:
  - mem_w_en=0.
  - Writes to KBSR and KBDR are ignored, except for the IE bit under the optional feature.
- DDR write accept rule: accepted when !disp_valid || disp_ready.
  - Accepted: disp_data<=cpu_w_data[7:0] and disp_valid<=1 at the edge.
  - Not accepted: the write is dropped and overrun<=1.
- Display handshake: disp_valid && disp_ready with no accepted write clears disp_valid at the edge. disp_valid and disp_data stay stable until the handshake.
- Any write to DSR clears overrun. Write data is otherwise ignored.
- rst mid-operation: FIFO contents are discarded and any pending display byte is dropped. rst has priority over all events in the same cycle.

Optional Feature:
- Macro PUNC_IO_IRQ_EN.
- Defined:
  - KBSR[14] becomes IE, written by cpu_w_data[14] on a KBSR write; reset value 0.
  - FIFO full moves to KBSR[13].
  - Adds output kb_irq = IE && nonempty (combinational).
- Undefined:
  - No kb_irq port.
  - KBSR[14]=full and KBSR[13]=0.
  - KBSR writes are fully ignored.

Test Plan:
- Reset, then read KBSR and DSR -> KBSR=16'h0000, DSR=16'h8000, kb_ready=1, disp_valid=0.
- Push 8'h41 then 8'h42 -> next cycle KBSR=16'h8000. KBDR read with cpu_r_en returns 16'h0041, then 16'h0042. KBSR then reads 16'h0000.
- Push 5 bytes 8'h01..8'h05 with DEPTH=4 -> after 4 pushes kb_ready=0 and KBSR=16'hC000. Byte 8'h05 is held off by kb_ready=0. Four pops return 8'h01..8'h04, and the FIFO accepts 8'h05 once not full. Pointers wrap correctly.
- Write DDR=16'h1263 with disp_ready=0 -> disp_valid=1, disp_data=8'h63, DSR=16'h0000. A second DDR write is dropped and DSR=16'h4000. disp_ready=1 for one cycle -> DSR=16'hC000. Write DSR -> DSR=16'h8000.
- Write 16'hBEEF to 16'h3000 and to 16'hFE06 -> mem_w_en=1 only for 16'h3000. Read 16'h3000 returns mem_r_data. Read 16'hFE01 returns mem_r_data.
- PUNC_IO_IRQ_EN build: write KBSR=16'h4000, then push 8'h0A -> kb_irq=1 the next cycle; pop -> kb_irq=0.
